// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
// Slot records carry register IDs of up to RD_W bits; narrower IDs are zero-extended.
package hazard_ctrl_pkg;

  localparam int ADDR_SIZE_DEFAULT = 5;
  localparam int RD_W              = 8;
  localparam int BP_RA             = 1;
  localparam int BP_RB             = 0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            ld;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // r0 is hardwired, so a write to it never makes the slot a producer.
  function automatic logic is_producer(slot_t s);
    return s.valid && s.we && (s.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and hazard/bypass response bundle for hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_W     = 16
);
  logic                 D_valid;
  logic [ADDR_SIZE-1:0] D_ra;
  logic [ADDR_SIZE-1:0] D_rb;
  logic                 D_use_ra;
  logic                 D_use_rb;
  logic [ADDR_SIZE-1:0] D_rd;
  logic                 D_we;
  logic                 D_ld;
  logic                 flush;
  logic [1:0]           EX_D_bp;
  logic [1:0]           MEM_D_bp;
  logic [1:0]           WB_D_bp;
  logic                 stall;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport master (
    output D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld, flush,
    input  EX_D_bp, MEM_D_bp, WB_D_bp, stall, stall_cnt, flush_cnt
  );

  modport slave (
    input  D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld, flush,
    output EX_D_bp, MEM_D_bp, WB_D_bp, stall, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// Compares one in-flight slot against the decode sources; returns {forward_ra, forward_rb}.
module hazard_match
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT
) (
  input  slot_t                slot,
  input  logic                 D_valid,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  input  logic                 D_use_ra,
  input  logic                 D_use_rb,
  output logic [1:0]           match
);
  logic producer;

  assign producer     = is_producer(slot);
  assign match[BP_RA] = D_valid && D_use_ra && producer && (slot.rd == RD_W'(D_ra));
  assign match[BP_RB] = D_valid && D_use_rb && producer && (slot.rd == RD_W'(D_rb));
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall detection, bypass selection and event counters for a
// decode stage followed by EX/MEM/WB slots.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  slot_t            slot_reg [3];
  logic [1:0]       match    [3];
  slot_t            ex_next;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      hazard_match #(.ADDR_SIZE(ADDR_SIZE)) u_match (
        .slot     (slot_reg[gi]),
        .D_valid  (bus.D_valid),
        .D_ra     (bus.D_ra),
        .D_rb     (bus.D_rb),
        .D_use_ra (bus.D_use_ra),
        .D_use_rb (bus.D_use_rb),
        .match    (match[gi])
      );
    end
  endgenerate

  // A flush kills the consumer, so it also cancels any load-use stall.
  always_comb begin
    stall   = !rst && !bus.flush && slot_reg[EX].ld && (|match[EX]);
    ex_next = SLOT_BUBBLE;
    if (bus.D_valid && !bus.flush && !stall) begin
      ex_next.valid = 1'b1;
      ex_next.rd    = RD_W'(bus.D_rd);
      ex_next.we    = bus.D_we;
      ex_next.ld    = bus.D_ld;
    end
  end

  // Load data is not ready in EX; that case is covered by the stall instead.
  assign bus.EX_D_bp  = (rst || slot_reg[EX].ld) ? 2'b00 : match[EX];
  assign bus.MEM_D_bp = rst ? 2'b00 : match[MEM];
  assign bus.WB_D_bp  = rst ? 2'b00 : match[WB];
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        slot_reg[i] <= SLOT_BUBBLE;
      end
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      slot_reg[EX]  <= ex_next;
      slot_reg[MEM] <= slot_reg[EX];
      slot_reg[WB]  <= slot_reg[MEM];
      if (stall && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (bus.flush && bus.D_valid && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end
endmodule
